soc_system_sysid_checker: RTL and testbench

Avalon-MM read master that checks the system ID peripheral in the HPS/FPGA SoC fabric. On a start pulse it reads the ID word (address 0) and the build timestamp word (address 1), compares each against build-time parameters, and reports pass/fail, the captured values and a per-read timeout. It sits beside the sysid slave on the same interconnect, so bring-up logic can confirm the FPGA image without HPS software.

---
 rtl/soc_system_sysid_checker.sv | 152 +++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master: reads sysid ID (addr 0) and timestamp (addr 1),
// compares against build parameters, reports pass/fail and per-read timeout.
module soc_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
   parameter logic [31:0] EXPECTED_TS    = 32'h523133F9,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, FIN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          read_q, read_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
   logic          pass_q, pass_d, id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, tmo_q, tmo_d;
   logic [31:0]   id_val_q, id_val_d, ts_val_q, ts_val_d;
   logic          in_xfer, expired;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      id_ok_d  = id_ok_q;
      ts_ok_d  = ts_ok_q;
      tmo_d    = tmo_q;
      id_val_d = id_val_q;
      ts_val_d = ts_val_q;

      in_xfer = (state_q == RD_ID) || (state_q == WT_ID) ||
                (state_q == RD_TS) || (state_q == WT_TS);
      expired = in_xfer && (cnt_q == CNT_MAX);
      // Saturating count so a stuck slave can never wrap the counter back into range
      if (in_xfer && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;

      case (state_q)
         IDLE: if (start) begin
            pass_d   = 1'b0;
            id_ok_d  = 1'b0;
            ts_ok_d  = 1'b0;
            tmo_d    = 1'b0;
            id_val_d = '0;
            ts_val_d = '0;
            cnt_d    = '0;
            state_d  = RD_ID;
         end
         RD_ID: begin
            if (expired) begin
               tmo_d   = 1'b1;
               state_d = FIN;
            end else if (!avm_waitrequest) state_d = WT_ID;
         end
         WT_ID: begin
            if (avm_readdatavalid) begin
               id_val_d = avm_readdata;
               id_ok_d  = (avm_readdata == EXPECTED_ID);
               cnt_d    = '0;
               state_d  = RD_TS;
            end else if (expired) begin
               tmo_d   = 1'b1;
               state_d = FIN;
            end
         end
         RD_TS: begin
            if (expired) begin
               tmo_d   = 1'b1;
               state_d = FIN;
            end else if (!avm_waitrequest) state_d = WT_TS;
         end
         WT_TS: begin
            if (avm_readdatavalid) begin
               ts_val_d = avm_readdata;
               ts_ok_d  = (avm_readdata == EXPECTED_TS);
               state_d  = FIN;
            end else if (expired) begin
               tmo_d   = 1'b1;
               state_d = FIN;
            end
         end
         FIN: begin
            pass_d  = id_ok_q & ts_ok_q & ~tmo_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Bus outputs are registered from the next state, so address is 0 whenever read is low
      read_d = (state_d == RD_ID) || (state_d == RD_TS);
      addr_d = (state_d == RD_TS);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         read_q   <= 1'b0;
         addr_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         id_ok_q  <= 1'b0;
         ts_ok_q  <= 1'b0;
         tmo_q    <= 1'b0;
         id_val_q <= '0;
         ts_val_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         read_q   <= read_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         id_ok_q  <= id_ok_d;
         ts_ok_q  <= ts_ok_d;
         tmo_q    <= tmo_d;
         id_val_q <= id_val_d;
         ts_val_q <= ts_val_d;
      end
   end

   assign avm_read    = read_q;
   assign avm_address = addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = tmo_q;
   assign id_value    = id_val_q;
   assign ts_value    = ts_val_q;
endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Bench for soc_system_sysid_checker: behavioural sysid slave plus a scoreboard
// of expected check results popped on each done pulse.
module tb_soc_system_sysid_checker;
   localparam logic [31:0] EXP_ID = 32'hACD51302;
   localparam logic [31:0] EXP_TS = 32'h523133F9;
   localparam int          TMO    = 8;

   typedef struct {
      logic        pass;
      logic        id_ok;
      logic        ts_ok;
      logic        tmo;
      logic [31:0] idv;
      logic [31:0] tsv;
   } exp_t;

   logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic        avm_address, avm_read;
   logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
   logic [31:0] avm_readdata = '0;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   soc_system_sysid_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
      .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
   );

   always #5 clock = ~clock;

   int n_checks = 0, n_errors = 0;
   int cyc = 0, n_done = 0, done_cyc = 0, acc_cnt = 0;
   exp_t sb[$];

   int          cfg_stall = 0, cfg_lat = 1;
   logic [31:0] cfg_id = EXP_ID, cfg_ts = EXP_TS;
   bit          cfg_drop_ts = 0, cfg_inject = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Slave model and done monitor, all evaluated on the falling edge
   initial begin
      int  stall_left = 0, lat_left = 0;
      bit  accepting = 0, lat_addr = 0, prev_rd = 0, prev_wr = 0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
            accepting = 0; lat_left = 0; stall_left = cfg_stall;
            prev_rd = 0; prev_wr = 0;
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (accepting) begin
               accepting = 0;
               if (!(cfg_drop_ts && lat_addr)) lat_left = cfg_lat;
            end
            if (lat_left > 0) begin
               lat_left--;
               if (lat_left == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = lat_addr ? cfg_ts : cfg_id;
               end
            end
            if (cfg_inject) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = EXP_TS;
            end
            if (prev_rd && prev_wr) begin
               chk("stall_read", 32'(avm_read), 1);
               chk("stall_addr", 32'(avm_address), 32'(acc_cnt % 2));
            end
            if (!avm_read) chk("addr_idle", 32'(avm_address), 0);
            if (avm_read) begin
               if (stall_left > 0) begin
                  avm_waitrequest = 1'b1;
                  stall_left--;
               end else begin
                  avm_waitrequest = 1'b0;
                  accepting = 1;
                  lat_addr  = avm_address;
                  chk("acc_addr", 32'(avm_address), 32'(acc_cnt % 2));
                  acc_cnt++;
                  stall_left = cfg_stall;
               end
            end else begin
               avm_waitrequest = 1'b0;
               stall_left = cfg_stall;
            end
            prev_rd = avm_read;
            prev_wr = avm_waitrequest;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               e = sb.pop_front();
               chk("pass", 32'(pass), 32'(e.pass));
               chk("id_ok", 32'(id_ok), 32'(e.id_ok));
               chk("ts_ok", 32'(ts_ok), 32'(e.ts_ok));
               chk("timeout", 32'(timeout), 32'(e.tmo));
               chk("id_value", id_value, e.idv);
               chk("ts_value", ts_value, e.tsv);
               chk("busy_at_done", 32'(busy), 0);
            end
         end
      end
   end

   function automatic exp_t model(input logic [31:0] id, input logic [31:0] ts, input bit drop);
      exp_t e;
      e.idv   = id;
      e.id_ok = (id == EXP_ID);
      e.tsv   = drop ? 32'h0 : ts;
      e.ts_ok = drop ? 1'b0 : (ts == EXP_TS);
      e.tmo   = drop;
      e.pass  = e.id_ok && e.ts_ok && !e.tmo;
      return e;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_read"}, 32'(avm_read), 0);
      chk({tag, "_addr"}, 32'(avm_address), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_id_ok"}, 32'(id_ok), 0);
      chk({tag, "_ts_ok"}, 32'(ts_ok), 0);
      chk({tag, "_tmo"}, 32'(timeout), 0);
      chk({tag, "_idv"}, id_value, 0);
      chk({tag, "_tsv"}, ts_value, 0);
   endtask

   task automatic kick(input exp_t e, output int t0);
      acc_cnt = 0;
      @(negedge clock);
      start = 1'b1;
      sb.push_back(e);
      @(posedge clock);
      #1 start = 1'b0;
      t0 = cyc;
      chk("busy_rise", 32'(busy), 1);
      chk("read_rise", 32'(avm_read), 1);
   endtask

   task automatic wait_done(input int n0, input int budget);
      int k = 0;
      while (n_done == n0 && k < budget) begin
         @(negedge clock);
         #1 k++;
      end
      if (n_done == n0) chk("done_wait", 0, 1);
   endtask

   task automatic run_check(input string tag, input int stall, input int lat,
                            input logic [31:0] id, input logic [31:0] ts,
                            input bit drop, input bit dup, input int exp_lat);
      exp_t e;
      int   t0, n0;
      cfg_stall = stall; cfg_lat = lat; cfg_id = id; cfg_ts = ts; cfg_drop_ts = drop;
      e  = model(id, ts, drop);
      n0 = n_done;
      kick(e, t0);
      if (dup) begin
         repeat (2) @(negedge clock);
         start = 1'b1;
         @(posedge clock);
         #1 start = 1'b0;
      end
      wait_done(n0, 200);
      if (exp_lat >= 0) chk({tag, "_latency"}, 32'(done_cyc - t0), 32'(exp_lat));
      repeat (4) @(negedge clock);
      #1;
      chk({tag, "_ndone"}, 32'(n_done - n0), 1);
      chk({tag, "_nreads"}, 32'(acc_cnt), 2);
      chk({tag, "_pass_held"}, 32'(pass), 32'(e.pass));
      chk({tag, "_idle"}, 32'(busy), 0);
   endtask

   initial begin
      int k, n0;
      repeat (3) @(negedge clock);
      #1 chk_reset_vals("rst");
      reset_n = 1'b1;

      run_check("nominal", 0, 1, EXP_ID, EXP_TS, 0, 0, 5);
      run_check("id_bad", 0, 1, 32'hDEADBEEF, EXP_TS, 0, 0, 5);
      run_check("ts_bad", 0, 1, EXP_ID, 32'h12345678, 0, 0, 5);
      run_check("stall", 3, 2, EXP_ID, EXP_TS, 0, 0, -1);
      run_check("dup_start", 0, 3, EXP_ID, EXP_TS, 0, 1, -1);

      run_check("tmo", 0, 1, EXP_ID, EXP_TS, 1, 0, TMO + 4);
      n0 = n_done;
      cfg_drop_ts = 0;
      @(posedge clock);
      #1 cfg_inject = 1;
      @(posedge clock);
      #1 cfg_inject = 0;
      repeat (2) @(negedge clock);
      #1;
      chk("late_ndone", 32'(n_done - n0), 0);
      chk("late_tmo", 32'(timeout), 1);
      chk("late_pass", 32'(pass), 0);
      chk("late_id_ok", 32'(id_ok), 1);
      chk("late_ts_ok", 32'(ts_ok), 0);
      chk("late_tsv", ts_value, 0);
      chk("late_idv", id_value, EXP_ID);

      // Reset while the TS read is stalled
      cfg_stall = 3; cfg_lat = 1; cfg_id = EXP_ID; cfg_ts = EXP_TS;
      kick(model(EXP_ID, EXP_TS, 0), k);
      k = 0;
      while (!(avm_read && avm_address) && k < 50) begin
         @(negedge clock);
         #1 k++;
      end
      chk("reach_rd_ts", 32'(avm_read && avm_address), 1);
      reset_n = 1'b0;
      #1 chk_reset_vals("midrst");
      sb.delete();
      repeat (2) @(negedge clock);
      #1 reset_n = 1'b1;
      run_check("post_rst", 0, 1, EXP_ID, EXP_TS, 0, 0, 5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
